// File: rtl/alp_fcon_pkg.sv
// Shared types and constants for the fcon config update controller.
// Holds the update FSM state enum, config field widths and the identity sync map.
package alp_fcon_pkg;

    localparam int MAX_RATE_W  = 5;
    localparam int RATE_CTRL_W = 32;
    localparam int SYNC_MAP_W  = 32;
    localparam int REF_W       = 3;
    localparam int UPD_CNT_W   = 8;

    // Each nibble selects its own channel: no remapping.
    localparam logic [SYNC_MAP_W-1:0] SYNC_MAP_IDENT = 32'h7654_3210;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_APPLY = 2'd2
    } upd_state_t;

endpackage

// File: rtl/alp_fcon_edge.sv
// Per-channel rising-edge detector for the raw frame-start inputs.
// Ports: i_clk, i_rst (async, active-high), i_fstart in, o_rise out (one-cycle pulses).
module alp_fcon_edge
    import alp_fcon_pkg::*;
#(
    parameter int NUM_PIX = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_PIX-1:0] i_fstart,
    output logic [NUM_PIX-1:0] o_rise
);

    logic [NUM_PIX-1:0] prev_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= i_fstart;
        end
    end

    assign o_rise = i_fstart & ~prev_q;

endmodule

// File: rtl/alp_fcon_upd.sv
// Frame-aligned commit of pending fcon config into the active config.
// Ports: i_clk, i_rst, i_upd_req/i_upd_abort pulses, i_ref_sel, i_pix_fstart,
//        i_pend_* config, i_tmo_max; o_act_* config, o_busy, o_upd_done,
//        o_upd_tmo, o_clr_sync pulses and o_upd_cnt apply counter.
module alp_fcon_upd
    import alp_fcon_pkg::*;
#(
    parameter int NUM_PIX = 8,
    parameter int TMO_W   = 20
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_upd_req,
    input  logic                   i_upd_abort,
    input  logic [REF_W-1:0]       i_ref_sel,
    input  logic [NUM_PIX-1:0]     i_pix_fstart,
    input  logic [MAX_RATE_W-1:0]  i_pend_max_rate,
    input  logic [RATE_CTRL_W-1:0] i_pend_rate_ctrl,
    input  logic [SYNC_MAP_W-1:0]  i_pend_sync_map,
    input  logic [TMO_W-1:0]       i_tmo_max,
    output logic [MAX_RATE_W-1:0]  o_act_max_rate,
    output logic [RATE_CTRL_W-1:0] o_act_rate_ctrl,
    output logic [SYNC_MAP_W-1:0]  o_act_sync_map,
    output logic                   o_busy,
    output logic                   o_upd_done,
    output logic                   o_upd_tmo,
    output logic                   o_clr_sync,
    output logic [UPD_CNT_W-1:0]   o_upd_cnt
);

    upd_state_t state_q;
    upd_state_t state_d;

    logic [MAX_RATE_W-1:0]  stg_max_rate_q;
    logic [RATE_CTRL_W-1:0] stg_rate_ctrl_q;
    logic [SYNC_MAP_W-1:0]  stg_sync_map_q;
    logic [REF_W-1:0]       stg_ref_q;
    logic [TMO_W-1:0]       tmo_cnt_q;
    logic                   tmo_flag_q;

    logic [NUM_PIX-1:0] rise;
    logic               ref_edge;
    logic               tmo_hit;
    logic               capture;
    logic               tmo_go;

    alp_fcon_edge #(
        .NUM_PIX (NUM_PIX)
    ) u_edge (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_fstart (i_pix_fstart),
        .o_rise   (rise)
    );

    // Out-of-range reference never matches a channel, so only the timeout can apply.
    always_comb begin
        ref_edge = 1'b0;
        for (int i = 0; i < NUM_PIX; i++) begin
            if (int'(stg_ref_q) == i) begin
                ref_edge = rise[i];
            end
        end
    end

    assign tmo_hit = (i_tmo_max != '0) &&
                     (tmo_cnt_q == i_tmo_max - TMO_W'(1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // WAIT priority: abort, then re-request, then reference edge, then timeout.
    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        tmo_go     = 1'b0;
        o_busy     = 1'b0;
        o_upd_done = 1'b0;
        o_clr_sync = 1'b0;
        o_upd_tmo  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_upd_req && !i_upd_abort) begin
                    capture = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                o_busy = 1'b1;
                if (i_upd_abort) begin
                    state_d = ST_IDLE;
                end else if (i_upd_req) begin
                    capture = 1'b1;
                end else if (ref_edge) begin
                    state_d = ST_APPLY;
                end else if (tmo_hit) begin
                    tmo_go  = 1'b1;
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                o_busy     = 1'b1;
                o_upd_done = 1'b1;
                o_clr_sync = 1'b1;
                o_upd_tmo  = tmo_flag_q;
                if (i_upd_req) begin
                    capture = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stg_max_rate_q  <= '0;
            stg_rate_ctrl_q <= '0;
            stg_sync_map_q  <= '0;
            stg_ref_q       <= '0;
            tmo_cnt_q       <= '0;
            tmo_flag_q      <= 1'b0;
            o_act_max_rate  <= '0;
            o_act_rate_ctrl <= '0;
            o_act_sync_map  <= SYNC_MAP_IDENT;
            o_upd_cnt       <= '0;
        end else begin
            tmo_flag_q <= tmo_go;
            if (capture) begin
                stg_max_rate_q  <= i_pend_max_rate;
                stg_rate_ctrl_q <= i_pend_rate_ctrl;
                stg_sync_map_q  <= i_pend_sync_map;
                stg_ref_q       <= i_ref_sel;
                tmo_cnt_q       <= '0;
            end else if (state_q == ST_WAIT) begin
                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end
            // Active config takes the stage contents before any same-cycle recapture.
            if (state_q == ST_APPLY) begin
                o_act_max_rate  <= stg_max_rate_q;
                o_act_rate_ctrl <= stg_rate_ctrl_q;
                o_act_sync_map  <= stg_sync_map_q;
                o_upd_cnt       <= o_upd_cnt + UPD_CNT_W'(1);
            end
        end
    end

endmodule
